// File: rtl/gray_to_rgb565_ise_pkg.sv
// gray_to_rgb565_ise_pkg: opcodes, FSM states and RGB565 field widths shared by the gray<->RGB565 ISEs.
package gray_to_rgb565_ise_pkg;
    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;
    typedef enum logic [1:0] {
        OP_CONVERT_LOW = 2'd0,
        OP_FETCH_HIGH  = 2'd1,
        OP_CLEAR       = 2'd2,
        OP_RSVD        = 2'd3
    } opcode_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/gray8_to_rgb565.sv
// gray8_to_rgb565: expands one 8-bit gray level to RGB565 by truncating the top bits into each field.
module gray8_to_rgb565
    import gray_to_rgb565_ise_pkg::*;
(
    input  logic [7:0]  gray,
    output logic [15:0] rgb
);
    assign rgb = {gray[7 -: R_W], gray[7 -: G_W], gray[7 -: B_W]};
endmodule

// File: rtl/gray_to_rgb565_ise.sv
// gray_to_rgb565_ise: custom instruction expanding packed gray pixels to RGB565, with a holding buffer for the upper pair.
module gray_to_rgb565_ise
    import gray_to_rgb565_ise_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter bit         SWAP_PIXELS         = 1'b0
)
(
    input  logic        clock,
    input  logic        nReset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  iseId,
    output logic        done,
    output logic [31:0] result
);
    state_e      state, state_nxt;
    opcode_e     op_q;
    logic [31:0] a_q;
    logic [15:0] hold;
    logic        hold_valid;
    logic        accept;
    logic        conv_ok;
    logic        unused_b;
    logic [7:0]  g_lo, g_hi;
    logic [15:0] px_lo, px_hi;
    logic [31:0] word;

    assign accept   = start && (iseId == customInstructionId);
    assign unused_b = ^valueB[31:2];
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = IDLE;
        state_nxt = (state == IDLE) ? (accept ? CALC : IDLE) :
                    (state == CALC) ? DONE : IDLE;
    end

    // FETCH_HIGH reuses the same expanders on the buffered upper pair.
    always_comb begin
        g_lo    = (op_q == OP_FETCH_HIGH) ? hold[7:0]  : a_q[7:0];
        g_hi    = (op_q == OP_FETCH_HIGH) ? hold[15:8] : a_q[15:8];
        word    = SWAP_PIXELS ? {px_lo, px_hi} : {px_hi, px_lo};
        conv_ok = (op_q == OP_CONVERT_LOW) || ((op_q == OP_FETCH_HIGH) && hold_valid);
    end

    gray8_to_rgb565 u_lo (.gray(g_lo), .rgb(px_lo));
    gray8_to_rgb565 u_hi (.gray(g_hi), .rgb(px_hi));

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            a_q        <= '0;
            op_q       <= OP_CONVERT_LOW;
            hold       <= '0;
            hold_valid <= 1'b0;
            result     <= '0;
        end else begin
            if (state == IDLE && accept) begin
                a_q  <= valueA;
                op_q <= opcode_e'(valueB[1:0]);
            end
            result <= (state == CALC && conv_ok) ? word : 32'h0;
            if (state == CALC) begin
                case (op_q)
                    OP_CONVERT_LOW: begin
                        hold       <= a_q[31:16];
                        hold_valid <= 1'b1;
                    end
                    OP_FETCH_HIGH: hold_valid <= 1'b0;
                    OP_CLEAR: begin
                        hold       <= '0;
                        hold_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gray_to_rgb565_ise.sv
// tb_gray_to_rgb565_ise: randomized and directed checks of the gray->RGB565 ISE against a behavioural model.
module tb_gray_to_rgb565_ise;
    localparam logic [7:0] ID = 8'h3C;
    localparam logic [7:0] SID = 8'h00;

    logic        clock = 1'b0;
    logic        nReset;
    logic        start;
    logic [31:0] valueA, valueB;
    logic [7:0]  iseId;
    logic        done, s_done;
    logic [31:0] result, s_result;
    int          checks = 0;
    int          passed = 0;
    logic [15:0] m_hold;
    logic        m_valid;

    always #5 clock = ~clock;

    gray_to_rgb565_ise #(.customInstructionId(ID), .SWAP_PIXELS(1'b0)) dut (
        .clock(clock), .nReset(nReset), .start(start), .valueA(valueA),
        .valueB(valueB), .iseId(iseId), .done(done), .result(result));

    gray_to_rgb565_ise #(.customInstructionId(SID), .SWAP_PIXELS(1'b1)) dut_swap (
        .clock(clock), .nReset(nReset), .start(start), .valueA(valueA),
        .valueB(valueB), .iseId(iseId), .done(s_done), .result(s_result));

    function automatic logic [15:0] px(input logic [7:0] g);
        int v;
        v = (g / 8) * 2048 + (g / 4) * 32 + (g / 8);
        return v[15:0];
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [31:0] a, output logic [31:0] r);
        r = 32'h0;
        if (op == 2'd0) begin
            r = {px(a[15:8]), px(a[7:0])};
            m_hold = a[31:16];
            m_valid = 1'b1;
        end else if (op == 2'd1) begin
            r = m_valid ? {px(m_hold[15:8]), px(m_hold[7:0])} : 32'h0;
            m_valid = 1'b0;
        end else if (op == 2'd2) begin
            m_hold = 16'h0;
            m_valid = 1'b0;
        end
    endtask

    // Issues one instruction and captures done over the three following cycles and result at N+2.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [7:0] id,
                          output logic [2:0] dv, output logic [31:0] rv, output logic [31:0] rz,
                          output logic [2:0] sdv, output logic [31:0] srv);
        @(negedge clock);
        start = 1'b1; valueA = a; valueB = {30'($urandom), op}; iseId = id;
        @(negedge clock);
        start = 1'b0; valueA = $urandom; valueB = $urandom;
        dv[0] = done; sdv[0] = s_done; rz = result;
        @(negedge clock);
        dv[1] = done; sdv[1] = s_done; rv = result; srv = s_result;
        @(negedge clock);
        dv[2] = done; sdv[2] = s_done; rz = rz | result;
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else passed++;
        nReset = 1'b1;
        m_hold = 16'h0; m_valid = 1'b0;
    endtask

    task automatic test_convert_fetch;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv;
        run_op(2'd0, 32'h123480FF, ID, dv, rv, rz, sdv, srv);
        m_hold = 16'h1234; m_valid = 1'b1;
        checks++; if (dv !== 3'b010) $display("FAIL conv_latency: got %b expected 010", dv); else passed++;
        checks++; if (rv !== 32'h8410FFFF) $display("FAIL conv_result: got %h expected 8410ffff", rv); else passed++;
        checks++; if (rz !== 32'h0) $display("FAIL conv_idle_result: got %h expected 00000000", rz); else passed++;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv);
        m_valid = 1'b0;
        checks++; if (rv !== 32'h108231A6) $display("FAIL fetch_result: got %h expected 108231a6", rv); else passed++;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv);
        checks++; if (dv !== 3'b010) $display("FAIL fetch2_done: got %b expected 010", dv); else passed++;
        checks++; if (rv !== 32'h0) $display("FAIL fetch2_result: got %h expected 00000000", rv); else passed++;
    endtask

    task automatic test_wrong_id;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv, exp;
        logic [31:0] a;
        a = $urandom;
        run_op(2'd0, a, ID, dv, rv, rz, sdv, srv);
        model_op(2'd0, a, exp);
        run_op(2'd0, 32'h000000FF, 8'h55, dv, rv, rz, sdv, srv);
        checks++; if (dv !== 3'b000) $display("FAIL wrongid_done: got %b expected 000", dv); else passed++;
        checks++; if ((rv | rz) !== 32'h0) $display("FAIL wrongid_result: got %h expected 00000000", rv | rz); else passed++;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv);
        model_op(2'd1, 32'h0, exp);
        checks++; if (rv !== exp) $display("FAIL wrongid_hold: got %h expected %h", rv, exp); else passed++;
    endtask

    task automatic test_start_held;
        logic [31:0] a1, a2, e1, e2, r2, r5;
        logic [6:1] dh;
        a1 = $urandom; a2 = $urandom;
        @(negedge clock);
        start = 1'b1; valueA = a1; valueB = 32'h0; iseId = ID;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            dh[k] = done;
            if (k == 2) r2 = result;
            if (k == 5) r5 = result;
            if (k == 3) valueA = a2;
            if (k == 4) start = 1'b0;
        end
        model_op(2'd0, a1, e1);
        model_op(2'd0, a2, e2);
        checks++; if (dh !== 6'b010010) $display("FAIL held_done_pattern: got %b expected 010010", dh); else passed++;
        checks++; if (r2 !== e1) $display("FAIL held_first_result: got %h expected %h", r2, e1); else passed++;
        checks++; if (r5 !== e2) $display("FAIL held_reaccept_result: got %h expected %h", r5, e2); else passed++;
    endtask

    task automatic test_reset_midop;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv;
        @(negedge clock);
        start = 1'b1; valueA = 32'hFFFF0000; valueB = 32'h0; iseId = ID;
        @(negedge clock);
        start = 1'b0; nReset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL midreset_result: got %h expected 00000000", result); else passed++;
        @(negedge clock);
        checks++; if (done !== 1'b0) $display("FAIL midreset_done_later: got %b expected 0", done); else passed++;
        nReset = 1'b1;
        m_hold = 16'h0; m_valid = 1'b0;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv);
        checks++; if (dv !== 3'b010) $display("FAIL postreset_fetch_done: got %b expected 010", dv); else passed++;
        checks++; if (rv !== 32'h0) $display("FAIL postreset_fetch_result: got %h expected 00000000", rv); else passed++;
    endtask

    task automatic test_clear_rsvd;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv, exp;
        logic [31:0] a;
        a = $urandom;
        run_op(2'd0, a, ID, dv, rv, rz, sdv, srv); model_op(2'd0, a, exp);
        run_op(2'd2, $urandom, ID, dv, rv, rz, sdv, srv); model_op(2'd2, 32'h0, exp);
        checks++; if (dv !== 3'b010 || rv !== 32'h0) $display("FAIL clear: got done %b result %h expected 010 00000000", dv, rv); else passed++;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv); model_op(2'd1, 32'h0, exp);
        checks++; if (rv !== 32'h0) $display("FAIL fetch_after_clear: got %h expected 00000000", rv); else passed++;
        a = $urandom;
        run_op(2'd0, a, ID, dv, rv, rz, sdv, srv); model_op(2'd0, a, exp);
        run_op(2'd3, $urandom, ID, dv, rv, rz, sdv, srv); model_op(2'd3, 32'h0, exp);
        checks++; if (dv !== 3'b010 || rv !== 32'h0) $display("FAIL rsvd: got done %b result %h expected 010 00000000", dv, rv); else passed++;
        run_op(2'd1, 32'h0, ID, dv, rv, rz, sdv, srv); model_op(2'd1, 32'h0, exp);
        checks++; if (rv !== exp) $display("FAIL fetch_after_rsvd: got %h expected %h", rv, exp); else passed++;
    endtask

    task automatic test_random;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv, exp;
        logic [31:0] a; logic [1:0] op; logic [7:0] id; logic acc;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; op = 2'($urandom);
            acc = ($urandom_range(3) != 0);
            id = acc ? ID : 8'($urandom);
            if (!acc && id == ID) id = ~ID;
            run_op(op, a, id, dv, rv, rz, sdv, srv);
            exp = 32'h0;
            if (acc) model_op(op, a, exp);
            checks++;
            if (dv !== (acc ? 3'b010 : 3'b000) || rv !== exp || rz !== 32'h0)
                $display("FAIL random_%0d: got done %b result %h idle %h expected done %b result %h", i, dv, rv, rz, acc ? 3'b010 : 3'b000, exp);
            else passed++;
        end
    endtask

    task automatic test_swap;
        logic [2:0] dv, sdv; logic [31:0] rv, rz, srv;
        run_op(2'd0, 32'h123480FF, SID, dv, rv, rz, sdv, srv);
        checks++; if (sdv !== 3'b010 || srv !== 32'hFFFF8410) $display("FAIL swap_conv: got done %b result %h expected 010 ffff8410", sdv, srv); else passed++;
        checks++; if (dv !== 3'b000) $display("FAIL swap_other_id_done: got %b expected 000", dv); else passed++;
        run_op(2'd1, 32'h0, SID, dv, rv, rz, sdv, srv);
        checks++; if (srv !== 32'h31A61082) $display("FAIL swap_fetch: got %h expected 31a61082", srv); else passed++;
    endtask

    initial begin
        start = 1'b0; valueA = '0; valueB = '0; iseId = '0; nReset = 1'b0;
        m_hold = '0; m_valid = 1'b0;
        test_reset;
        test_convert_fetch;
        test_wrong_id;
        test_start_held;
        test_reset_midop;
        test_clear_rsvd;
        test_random;
        test_swap;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
